// File: rtl/ramen_customer.sv
// Customer-side initiator for the ramen shop engine. Orders are queued in a
// small FIFO, sent to the shop as two-beat transfers inside one selling session,
// and tallied from the replies. At the end of the session the shop's reported
// totals are compared against that tally.
module ramen_customer #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ord_wr,
  input  logic [1:0]             ord_type,
  input  logic                   ord_portion,
  output logic                   ord_full,
  output logic [$clog2(DEPTH):0] ord_count,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [27:0]            exp_sold_num,
  output logic [14:0]            exp_gain,
  output logic [7:0]             succ_cnt,
  output logic [7:0]             fail_cnt,
  output logic                   err_timeout,
  output logic                   err_mismatch,
  output logic                   in_valid,
  output logic                   selling,
  output logic                   portion,
  output logic [1:0]             ramen_type,
  input  logic                   out_valid_order,
  input  logic                   success,
  input  logic                   out_valid_tot,
  input  logic [27:0]            sold_num,
  input  logic [14:0]            total_gain
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [14:0] GAIN_PLAIN = 15'd200;
  localparam logic [14:0] GAIN_SOY   = 15'd250;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_BEAT1    = 3'd1;
  localparam logic [2:0] S_BEAT2    = 3'd2;
  localparam logic [2:0] S_WAIT_ORD = 3'd3;
  localparam logic [2:0] S_CLOSE    = 3'd4;
  localparam logic [2:0] S_WAIT_TOT = 3'd5;

  logic [2:0]    state;
  logic [2:0]    nstate;
  logic          accept;
  logic          tmo_hit;
  logic          reply_ord;
  logic          reply_tot;
  logic [TW-1:0] tmo;
  logic [1:0]    cur_type;

  // FIFO storage: each entry is {type, portion}
  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt_nxt;
  logic [2:0]    head;
  logic          push;
  logic          pop;

  assign push      = ord_wr && !ord_full;
  assign pop       = (state == S_BEAT2);
  assign head      = mem[rd_ptr];
  assign reply_ord = (state == S_WAIT_ORD) && out_valid_order;
  assign reply_tot = (state == S_WAIT_TOT) && out_valid_tot;

  // FIFO entry write; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {ord_type, ord_portion};
    end
  end

  // Occupancy after this cycle's push/pop; a simultaneous pair cancels out
  always_comb begin
    cnt_nxt = ord_count;
    if (push && !pop) begin
      cnt_nxt = ord_count + CW'(1);
    end else if (pop && !push) begin
      cnt_nxt = ord_count - CW'(1);
    end
  end

  // FIFO pointers, occupancy and registered full flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ord_count <= '0;
      ord_full  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      ord_count <= cnt_nxt;
      ord_full  <= (cnt_nxt == FULL_CNT);
    end
  end

  // Session sequencing: next state plus start-accept and timeout strobes
  always_comb begin
    nstate  = state;
    accept  = 1'b0;
    tmo_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && (ord_count != '0)) begin
          nstate = S_BEAT1;
          accept = 1'b1;
        end
      end
      S_BEAT1: nstate = S_BEAT2;
      S_BEAT2: nstate = S_WAIT_ORD;
      S_WAIT_ORD: begin
        if (out_valid_order) begin
          nstate = (ord_count != '0) ? S_BEAT1 : S_CLOSE;
        end else if (tmo == TMO_LAST) begin
          nstate  = S_IDLE;
          tmo_hit = 1'b1;
        end
      end
      S_CLOSE: nstate = S_WAIT_TOT;
      S_WAIT_TOT: begin
        if (out_valid_tot) begin
          nstate = S_IDLE;
        end else if (tmo == TMO_LAST) begin
          nstate  = S_IDLE;
          tmo_hit = 1'b1;
        end
      end
      default: nstate = S_IDLE;
    endcase
  end

  // State register and shop-facing pins, loaded from the next state so the
  // pins line up with the state they belong to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      selling    <= 1'b0;
      in_valid   <= 1'b0;
      ramen_type <= 2'd0;
      portion    <= 1'b0;
      cur_type   <= 2'd0;
    end else begin
      state      <= nstate;
      selling    <= (nstate == S_BEAT1) || (nstate == S_BEAT2) || (nstate == S_WAIT_ORD);
      in_valid   <= (nstate == S_BEAT1) || (nstate == S_BEAT2);
      ramen_type <= (nstate == S_BEAT1) ? head[2:1] : 2'd0;
      portion    <= (nstate == S_BEAT2) ? head[0] : 1'b0;
      if (pop) begin
        cur_type <= head[2:1];
      end
    end
  end

  // Reply timer: cleared entering WAIT_ORD or CLOSE, runs while a reply is awaited
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo <= '0;
    end else if (((nstate == S_WAIT_ORD) && (state != S_WAIT_ORD)) || (nstate == S_CLOSE)) begin
      tmo <= '0;
    end else if ((state == S_WAIT_ORD) || (state == S_WAIT_TOT)) begin
      tmo <= tmo + TW'(1);
    end
  end

  // Own tally of sold bowls, gain and reply counts for the current session
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_sold_num <= '0;
      exp_gain     <= '0;
      succ_cnt     <= '0;
      fail_cnt     <= '0;
    end else if (accept) begin
      exp_sold_num <= '0;
      exp_gain     <= '0;
      succ_cnt     <= '0;
      fail_cnt     <= '0;
    end else if (reply_ord) begin
      if (success) begin
        case (cur_type)
          2'd0: exp_sold_num[27:21] <= exp_sold_num[27:21] + 7'd1;
          2'd1: exp_sold_num[20:14] <= exp_sold_num[20:14] + 7'd1;
          2'd2: exp_sold_num[13:7]  <= exp_sold_num[13:7]  + 7'd1;
          2'd3: exp_sold_num[6:0]   <= exp_sold_num[6:0]   + 7'd1;
        endcase
        exp_gain <= exp_gain + (cur_type[0] ? GAIN_SOY : GAIN_PLAIN);
        if (succ_cnt != 8'hFF) begin
          succ_cnt <= succ_cnt + 8'd1;
        end
      end else if (fail_cnt != 8'hFF) begin
        fail_cnt <= fail_cnt + 8'd1;
      end
    end
  end

  // Session status: busy, completion pulse and error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      err_timeout  <= 1'b0;
      err_mismatch <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        busy         <= 1'b1;
        err_timeout  <= 1'b0;
        err_mismatch <= 1'b0;
      end
      if (tmo_hit) begin
        busy        <= 1'b0;
        done        <= 1'b1;
        err_timeout <= 1'b1;
      end
      if (reply_tot) begin
        busy         <= 1'b0;
        done         <= 1'b1;
        err_mismatch <= (sold_num != exp_sold_num) || (total_gain != exp_gain);
      end
    end
  end

endmodule

// File: tb/tb_ramen_customer.sv
// Directed bench for ramen_customer: the bench plays the shop, replying to
// each two-beat order and reporting end-of-day totals, with hand-computed
// expectations.
module tb_ramen_customer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ord_wr = 1'b0;
  logic [1:0]  ord_type = 2'd0;
  logic        ord_portion = 1'b0;
  logic        ord_full;
  logic [4:0]  ord_count;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [27:0] exp_sold_num;
  logic [14:0] exp_gain;
  logic [7:0]  succ_cnt;
  logic [7:0]  fail_cnt;
  logic        err_timeout;
  logic        err_mismatch;
  logic        in_valid;
  logic        selling;
  logic        portion;
  logic [1:0]  ramen_type;
  logic        out_valid_order = 1'b0;
  logic        success = 1'b0;
  logic        out_valid_tot = 1'b0;
  logic [27:0] sold_num = '0;
  logic [14:0] total_gain = '0;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  ramen_customer #(.DEPTH(16), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .ord_wr(ord_wr), .ord_type(ord_type), .ord_portion(ord_portion),
    .ord_full(ord_full), .ord_count(ord_count),
    .start(start), .busy(busy), .done(done),
    .exp_sold_num(exp_sold_num), .exp_gain(exp_gain),
    .succ_cnt(succ_cnt), .fail_cnt(fail_cnt),
    .err_timeout(err_timeout), .err_mismatch(err_mismatch),
    .in_valid(in_valid), .selling(selling), .portion(portion), .ramen_type(ramen_type),
    .out_valid_order(out_valid_order), .success(success), .out_valid_tot(out_valid_tot),
    .sold_num(sold_num), .total_gain(total_gain)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ord_wr = 1'b0; start = 1'b0;
    out_valid_order = 1'b0; success = 1'b0; out_valid_tot = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(input logic [1:0] t, input logic p);
    ord_wr = 1'b1; ord_type = t; ord_portion = p;
    @(negedge clk);
    ord_wr = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  // Observe one order's two beats, optionally push during the pop beat, then reply
  task automatic serve(input logic [1:0] t, input logic p, input logic succ, input int lat,
                       input logic push_b2, input logic [1:0] pt, input logic pp,
                       input int cnt_after);
    int n = 0;
    while (!in_valid && n < 20) begin @(negedge clk); n++; end
    check("beat1_valid", in_valid, 1);
    check("beat1_type", ramen_type, t);
    check("beat1_portion", portion, 0);
    check("beat1_selling", selling, 1);
    @(negedge clk);
    check("beat2_valid", in_valid, 1);
    check("beat2_portion", portion, p);
    check("beat2_type", ramen_type, 0);
    if (push_b2) begin ord_wr = 1'b1; ord_type = pt; ord_portion = pp; end
    @(negedge clk);
    ord_wr = 1'b0;
    check("pop_count", ord_count, cnt_after);
    repeat (lat - 1) @(negedge clk);
    check("wait_selling", selling, 1);
    check("wait_in_valid", in_valid, 0);
    out_valid_order = 1'b1; success = succ;
    @(negedge clk);
    out_valid_order = 1'b0; success = 1'b0;
  endtask

  // Called in the CLOSE cycle; answer in WAIT_TOT and check the verdict
  task automatic close(input logic [27:0] sn, input logic [14:0] tg, input logic exp_mm,
                       input logic [27:0] exs, input logic [14:0] exg);
    check("close_selling", selling, 0);
    check("close_busy", busy, 1);
    @(negedge clk);
    out_valid_tot = 1'b1; sold_num = sn; total_gain = tg;
    @(negedge clk);
    out_valid_tot = 1'b0;
    check("done_pulse", done, 1);
    check("busy_fall", busy, 0);
    check("mismatch", err_mismatch, exp_mm);
    check("timeout_flag", err_timeout, 0);
    check("exp_sold", exp_sold_num, exs);
    check("exp_gain", exp_gain, exg);
    @(negedge clk);
    check("done_single", done, 0);
  endtask

  initial begin
    int n;
    // reset values
    repeat (2) @(negedge clk);
    check("rst_count", ord_count, 0);
    check("rst_full", ord_full, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sold", exp_sold_num, 0);
    check("rst_gain", exp_gain, 0);
    check("rst_succ", succ_cnt, 0);
    check("rst_fail", fail_cnt, 0);
    check("rst_tmo", err_timeout, 0);
    check("rst_mm", err_mismatch, 0);
    check("rst_pins", {in_valid, selling, portion, ramen_type}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // start with empty FIFO is ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("empty_start_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("empty_start_done", done_cnt, 0);
    check("empty_start_sell", selling, 0);

    // one TONKOTSU small order
    push(2'd0, 1'b0);
    check("one_count", ord_count, 1);
    kick();
    serve(2'd0, 1'b0, 1'b1, 3, 1'b0, 2'd0, 1'b0, 0);
    close(28'h0200000, 15'd200, 1'b0, 28'h0200000, 15'd200);
    check("one_succ", succ_cnt, 1);
    check("one_fail", fail_cnt, 0);
    check("one_done_cnt", done_cnt, 1);

    // four big orders, one of each type
    for (int i = 0; i < 4; i++) push(2'(i), 1'b1);
    kick();
    serve(2'd0, 1'b1, 1'b1, 1, 1'b0, 2'd0, 1'b0, 3);
    serve(2'd1, 1'b1, 1'b1, 2, 1'b0, 2'd0, 1'b0, 2);
    serve(2'd2, 1'b1, 1'b1, 3, 1'b0, 2'd0, 1'b0, 1);
    serve(2'd3, 1'b1, 1'b1, 5, 1'b0, 2'd0, 1'b0, 0);
    close(28'h0204081, 15'd900, 1'b0, 28'h0204081, 15'd900);
    check("four_succ", succ_cnt, 4);
    check("four_done_cnt", done_cnt, 2);

    // second order fails, shop over-reports gain
    push(2'd0, 1'b0);
    push(2'd1, 1'b0);
    kick();
    serve(2'd0, 1'b0, 1'b1, 2, 1'b0, 2'd0, 1'b0, 1);
    serve(2'd1, 1'b0, 1'b0, 2, 1'b0, 2'd0, 1'b0, 0);
    close(28'h0200000, 15'd450, 1'b1, 28'h0200000, 15'd200);
    check("fail_fail", fail_cnt, 1);
    check("fail_succ", succ_cnt, 1);
    check("fail_done_cnt", done_cnt, 3);

    // push coinciding with the BEAT2 pop; the late order joins this session
    push(2'd3, 1'b0);
    kick();
    serve(2'd3, 1'b0, 1'b1, 3, 1'b1, 2'd2, 1'b1, 1);
    serve(2'd2, 1'b1, 1'b1, 2, 1'b0, 2'd0, 1'b0, 0);
    close(28'h0000081, 15'd450, 1'b0, 28'h0000081, 15'd450);
    check("late_done_cnt", done_cnt, 4);

    // shop never replies
    do_reset();
    push(2'd0, 1'b0);
    push(2'd1, 1'b1);
    push(2'd2, 1'b0);
    kick();
    check("tmo_beat1", in_valid, 1);
    @(negedge clk);
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 200);
    check("tmo_latency", n, 65);
    check("tmo_flag", err_timeout, 1);
    check("tmo_selling", selling, 0);
    check("tmo_in_valid", in_valid, 0);
    check("tmo_busy", busy, 0);
    check("tmo_count", ord_count, 2);

    // overfill the FIFO
    do_reset();
    for (int i = 0; i < 16; i++) begin
      push(2'(i), 1'(i));
      if (i == 14) check("full_at_15", ord_full, 0);
    end
    check("full_at_16", ord_full, 1);
    check("count_16", ord_count, 16);
    push(2'd3, 1'b1);
    check("count_17", ord_count, 16);
    check("full_17", ord_full, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule

// File: doc/ramen_customer.md
# ramen_customer

Order-issuing counterpart of the ramen shop engine. It queues host-supplied orders, drives them onto the shop's two-beat order interface inside one selling session, and logs every `success` reply. It then closes the session and cross-checks the shop's end-of-day `sold_num`/`total_gain` against its own tally. It sits in the shop testbench/SoC as the customer-side initiator.

## Interface
- `DEPTH`, 16: order FIFO entries (power of 2, ≥2).
- `TIMEOUT`, 64: max cycles waited for any shop response (≥8).

- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `ord_wr`  in  1  push order into FIFO
- `ord_type`  in  2  0 TONKOTSU, 1 TONKOTSU_SOY, 2 MISO, 3 MISO_SOY
- `ord_portion`  in  1  0 small, 1 big
- `ord_full`  out  1  FIFO full
- `ord_count`  out  $clog2(DEPTH)+1  FIFO occupancy
- `start`  in  1  begin session (IDLE only)
- `busy`  out  1  high from the cycle after an accepted start until done
- `done`  out  1  one-cycle completion pulse
- `exp_sold_num`  out  28  own tally, {T, TS, M, MS} 7 bits each, T at [27:21]
- `exp_gain`  out  15  own tally of gain
- `succ_cnt`, `fail_cnt`  out  8 each  replies with success = 1 / 0
- `err_timeout`  out  1  session aborted on timeout
- `err_mismatch`  out  1  shop totals ≠ own tally
- `in_valid`, `selling`, `portion`  out  1 each  shop order interface
- `ramen_type`  out  2  shop order interface
- `out_valid_order`, `success`, `out_valid_tot`  in  1 each  shop replies
- `sold_num`  in  28  shop totals
- `total_gain`  in  15  shop totals

## Operation
- All outputs are registered and reset to 0. FIFO is empty on reset.
- FIFO: push when `ord_wr && !ord_full`; a push while full is dropped. Pops happen only in BEAT2. A simultaneous push and pop keeps the count unchanged. Pushes are accepted in any state; an order pushed before the FIFO is found empty at a reply is sent in the current session.
- FSM: IDLE, BEAT1, BEAT2, WAIT_ORD, CLOSE, WAIT_TOT.
- IDLE:
  - `start` with `ord_count != 0` moves to BEAT1 and clears the tallies, counters and error flags.
  - `start` with an empty FIFO is ignored; no session opens and `done` is not pulsed.
- BEAT1: `selling=1`, `in_valid=1`, `ramen_type`=head type, `portion=0`. Next state BEAT2.
- BEAT2: `selling=1`, `in_valid=1`, `portion`=head portion, `ramen_type=0`. Pops the head. Next state WAIT_ORD.
- WAIT_ORD: `selling=1`, `in_valid=0`. On `out_valid_order`:
  - `success=1`: increment the type field of `exp_sold_num` (mod 128). Add 200 (types 0/2) or 250 (types 1/3) to `exp_gain` (mod 2^15). Increment `succ_cnt`.
  - `success=0`: increment `fail_cnt`.
  - Both counters saturate at 255.
  - Next state is BEAT1 if the FIFO is non-empty, else CLOSE.
- CLOSE: `selling=0` for one cycle, then WAIT_TOT.
- WAIT_TOT: `selling=0`. On `out_valid_tot`, set `err_mismatch = (sold_num != exp_sold_num) || (total_gain != exp_gain)`, pulse `done`, return to IDLE.
- Timeout: a counter clears on entry to WAIT_ORD or CLOSE and counts in WAIT_ORD and WAIT_TOT. When it reaches `TIMEOUT` without the awaited reply: set `err_timeout`, drive `selling=0` and `in_valid=0`, pulse `done`, go to IDLE. FIFO contents are retained.
- A reply of the wrong kind for the current state (e.g. `out_valid_tot` in WAIT_ORD) is ignored.
- Results stay stable until the next accepted `start`.
- Reset mid-session: everything returns to reset values immediately and queued orders are lost.

## Timing
- An accepted `start` at edge t puts beat 1 on the pins during cycle t+1 and beat 2 during t+2.
- Shop reply at cycle t+5, assuming a 3-cycle shop turnaround; the design tolerates any latency ≤ `TIMEOUT`.
- Next order's beat 1 is on the pins the cycle after `out_valid_order`.
- Closing sequence:
  - Last reply at cycle r.
  - `selling=0` from r+1.
  - Expected `out_valid_tot` at r+3.
  - `done` and `err_mismatch` valid in the cycle after `out_valid_tot` is sampled.
- `selling` stays 1 continuously from BEAT1 of the first order through WAIT_ORD of the last, so the shop never sees `selling=0` while an order is in flight.
- `busy` falls in the same cycle `done` is high.

## Test plan
- Reset: all outputs 0, `ord_count=0`. A `start` with an empty FIFO leaves `busy=0` and no `done`.
- One TONKOTSU small order, shop replies success=1, then reports `sold_num=28'h0200000` and `total_gain=200`: `exp_sold_num=28'h0200000`, `exp_gain=200`, `succ_cnt=1`, `err_mismatch=0`, `done` pulsed once.
- Four orders, types 0,1,2,3 (big), all succeed; shop totals `28'h0204081` and 900: pins show 4×(type beat, portion beat) with `portion=1`, `err_mismatch=0`.
- Two orders, the second replies success=0; shop reports `total_gain=450` against an expected 200: `fail_cnt=1`, `err_mismatch=1`.
- Shop never asserts `out_valid_order`: `err_timeout=1` after 64 cycles, `selling=0`, FIFO count equals the orders not yet popped.
- Push 17 orders with `DEPTH=16`: `ord_full=1` after the 16th push, the 17th is dropped, `ord_count=16`. A push in the same cycle as a BEAT2 pop keeps the count unchanged.
